dmem_initiator: RTL

//  Load/store initiator for the stalling data memory port: takes one request at a time from the

---
 rtl/dmem_initiator.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dmem_initiator.sv
// Single-outstanding load/store initiator between the MEM stage and the stalling data memory port.
// Optional build macro: DMEM_MISALIGN_TRAP_EN turns misaligned half/word requests into errors.
module dmem_initiator #(
  parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
  parameter logic [31:0] DMEM_LIMIT = 32'h0000_0FFF,
  parameter logic [31:0] MMIO_ADDR  = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        seen_stall_q, seen_stall_d;
  logic        req_ready_d, resp_valid_d, resp_err_d;
  logic [31:0] resp_rdata_d, mem_addr_d, mem_write_data_d;
  logic        mem_memread_d, mem_memwrite_d;
  logic [3:0]  mem_sign_mask_d;

  logic        is_word, is_half, in_range, misalign, accept_ok;
  logic [3:0]  req_mask;

  // Reserved size 2'b11 behaves as a word access.
  assign is_word = req_size[1];
  assign is_half = (req_size == 2'b01);
  assign req_mask = {req_signed & ~req_write & ~is_word, is_word, is_word | is_half, 1'b1};

  // Offset compare keeps a single unsigned test even when DMEM_BASE is zero.
  assign in_range = ((req_addr - DMEM_BASE) <= (DMEM_LIMIT - DMEM_BASE)) ||
                    (req_addr == MMIO_ADDR);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = (is_half & req_addr[0]) | (is_word & (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign accept_ok = in_range & ~misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      seen_stall_q   <= 1'b0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      mem_sign_mask  <= '0;
    end else begin
      state_q        <= state_d;
      seen_stall_q   <= seen_stall_d;
      req_ready      <= req_ready_d;
      resp_valid     <= resp_valid_d;
      resp_rdata     <= resp_rdata_d;
      resp_err       <= resp_err_d;
      mem_addr       <= mem_addr_d;
      mem_write_data <= mem_write_data_d;
      mem_memread    <= mem_memread_d;
      mem_memwrite   <= mem_memwrite_d;
      mem_sign_mask  <= mem_sign_mask_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    seen_stall_d     = seen_stall_q;
    req_ready_d      = req_ready;
    resp_valid_d     = resp_valid;
    resp_rdata_d     = resp_rdata;
    resp_err_d       = resp_err;
    mem_addr_d       = mem_addr;
    mem_write_data_d = mem_write_data;
    mem_memread_d    = mem_memread;
    mem_memwrite_d   = mem_memwrite;
    mem_sign_mask_d  = mem_sign_mask;

    unique case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          req_ready_d      = 1'b0;
          mem_addr_d       = req_addr;
          mem_write_data_d = req_wdata;
          mem_sign_mask_d  = req_mask;
          if (accept_ok) begin
            mem_memread_d  = ~req_write;
            mem_memwrite_d = req_write;
            state_d        = S_ISSUE;
          end else begin
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
          end
        end
      end
      // Memory has sampled the strobe on this edge; drop it so it does not re-trigger.
      S_ISSUE: begin
        mem_memread_d  = 1'b0;
        mem_memwrite_d = 1'b0;
        state_d        = S_WAIT;
      end
      S_WAIT: begin
        if (mem_clk_stall) begin
          seen_stall_d = 1'b1;
        end else if (seen_stall_q) begin
          resp_rdata_d = mem_sign_mask[3:0] == 4'b0000 ? '0 :
                         (req_wr_latched() ? '0 : mem_read_data);
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          seen_stall_d = 1'b0;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The store/load direction of the in-flight request, remembered from the issued strobe.
  logic wr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        wr_q <= 1'b0;
    else if (state_q == S_IDLE && req_valid) wr_q <= req_write;
  end

  function automatic logic req_wr_latched();
    return wr_q;
  endfunction

endmodule
